seg_scan_decoder: RTL and testbench

//   Receive-side counterpart of the multiplexed 4-digit 7-segment driver.
//   - Samples the scanned disp/anode bus and qualifies each pattern for stability.
//   - Decodes each glyph back to a 4-bit hex value and stores one value per digit.
//   - Used as an in-fabric checker and loopback monitor for display drivers.

---
 rtl/seg_scan_pkg.sv | 61 ++++++
 rtl/seg_glyph_dec.sv | 21 ++
 rtl/seg_scan_decoder.sv | 171 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types, glyph table and anode one-hot helper for the 7-segment scan decoder.
// Glyphs are stored active-high as {a,b,c,d,e,f,g}.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StQual,
        StHold
    } state_e;

    localparam int unsigned MAX_DIGITS = 16;
    localparam int unsigned IDX_W      = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

    typedef enum logic [1:0] {
        OhNone,
        OhOne,
        OhMany
    } onehot_kind_e;

    typedef struct packed {
        onehot_kind_e           kind;
        logic [IDX_W-1:0]       idx;
    } onehot_t;

    function automatic onehot_t onehot_check(input logic [MAX_DIGITS-1:0] v);
        onehot_t r;
        r.kind = OhNone;
        r.idx  = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (v[i]) begin
                if (r.kind == OhNone) begin
                    r.kind = OhOne;
                    r.idx  = i[IDX_W-1:0];
                end else begin
                    r.kind = OhMany;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational 7-segment glyph decoder: active-high {a..g} pattern to {valid, hex}.
module seg_glyph_dec
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] hex
);

    always_comb begin
        valid = 1'b0;
        hex   = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPH[i]) begin
                valid = 1'b1;
                hex   = i[3:0];
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 7-segment scan bus with stability qualification.
// Define SEG_SCAN_SYNC_EN to insert a 2-flop input synchroniser (+2 cycles latency).
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              disp,
    input  logic [NUM_DIGITS-1:0]   anode,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    seg_err,
    output logic                    anode_err
);

    localparam int unsigned SW    = NUM_DIGITS + 7;
    localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SW-1:0] samp;

`ifdef SEG_SCAN_SYNC_EN
    logic [SW-1:0] sync1_q, sync2_q;

    // Synchroniser idles at the inactive bus level so reset looks like blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {SW{ACTIVE_LOW}};
            sync2_q <= {SW{ACTIVE_LOW}};
        end else begin
            sync1_q <= {anode, disp};
            sync2_q <= sync1_q;
        end
    end

    assign samp = sync2_q;
`else
    assign samp = {anode, disp};
`endif

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]           prev_q;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    frame_q, frame_d;
    logic                    segerr_q, segerr_d;
    logic                    anerr_q, anerr_d;

    logic [SW-1:0]           norm;
    logic [MAX_DIGITS-1:0]   an_ext;
    logic                    changed;
    logic                    capture;
    logic                    glyph_valid;
    logic [3:0]              glyph_hex;
    onehot_t                 oh;

    assign norm    = ACTIVE_LOW ? ~samp : samp;
    assign changed = (samp != prev_q);

    seg_glyph_dec u_glyph (
        .seg   (norm[6:0]),
        .valid (glyph_valid),
        .hex   (glyph_hex)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StQual;
                cnt_d   = '0;
            end
            StQual: begin
                if (changed) begin
                    cnt_d = '0;
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_MAX) begin
                        capture = 1'b1;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (changed) begin
                    state_d = StQual;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        frame_d  = 1'b0;
        segerr_d = 1'b0;
        anerr_d  = 1'b0;
        an_ext   = '0;
        an_ext[NUM_DIGITS-1:0] = norm[SW-1:7];
        oh       = onehot_check(an_ext);
        if (capture) begin
            case (oh.kind)
                OhOne: begin
                    if (glyph_valid) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (int'(oh.idx) == i) begin
                                digits_d[4*i +: 4] = glyph_hex;
                                valid_d[i]         = 1'b1;
                                seen_d[i]          = 1'b1;
                            end
                        end
                    end else begin
                        segerr_d = 1'b1;
                    end
                end
                OhMany:  anerr_d = 1'b1;
                default: ;
            endcase
        end
        // The completing digit belongs to this frame; the next frame starts empty.
        if (&seen_d) begin
            frame_d = 1'b1;
            seen_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            prev_q   <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            segerr_q <= 1'b0;
            anerr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= samp;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            segerr_q <= segerr_d;
            anerr_q  <= anerr_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_q;
    assign seg_err     = segerr_q;
    assign anode_err   = anerr_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder (4 digits, STABLE_CYCLES=4, active-low).
// Build with SEG_SCAN_SYNC_EN defined to exercise the synchronised input path.
module tb_seg_scan_decoder;

`ifdef SEG_SCAN_SYNC_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    localparam logic [6:0] G0    = 7'b0000001;
    localparam logic [6:0] G1    = 7'b1001111;
    localparam logic [6:0] G5    = 7'b0100100;
    localparam logic [6:0] G8    = 7'b0000000;
    localparam logic [6:0] GA    = 7'b0001000;
    localparam logic [6:0] GF    = 7'b0111000;
    localparam logic [6:0] BAD   = 7'b1111110;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  disp = BLANK;
    logic [3:0]  anode = 4'b1111;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done, seg_err, anode_err;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0, se_cnt = 0, ae_cnt = 0;

    always #10 clk = ~clk;

    seg_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .disp        (disp),
        .anode       (anode),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .seg_err     (seg_err),
        .anode_err   (anode_err)
    );

    // Pulse counters sampled mid-cycle; checks run 1 ns after the same negedge.
    always @(negedge clk) begin
        if (rst_n) begin
            fd_cnt = fd_cnt + int'(frame_done);
            se_cnt = se_cnt + int'(seg_err);
            ae_cnt = ae_cnt + int'(anode_err);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] d, input int n);
        anode = a;
        disp  = d;
        step(n);
    endtask

    task automatic do_reset();
        anode = 4'b1111;
        disp  = BLANK;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (digits !== 16'h0000 || digit_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_regs: digits=%h valid=%b, required 0000/0000", digits, digit_valid);
        end
        checks++;
        if ({frame_done, seg_err, anode_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: fd/se/ae=%b, required 000",
                     {frame_done, seg_err, anode_err});
        end
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int fd0;
        do_reset();
        fd0 = fd_cnt;
        drive(4'b1110, G1, 8);
        checks++;
        if (digits[3:0] !== 4'h1 || digit_valid !== 4'b0001) begin
            errors++;
            $display("FAIL scan_d0: digit0=%h valid=%b, required 1/0001", digits[3:0], digit_valid);
        end
        drive(4'b1101, G0, 8);
        drive(4'b1011, GA, 8);
        drive(4'b0111, GF, LAT - 1);
        checks++;
        if (digits[15:12] !== 4'h0 || fd_cnt - fd0 !== 0) begin
            errors++;
            $display("FAIL scan_early: digit3=%h frames=%0d, required 0/0",
                     digits[15:12], fd_cnt - fd0);
        end
        step(1);
        checks++;
        if (digits !== 16'hFA01 || digit_valid !== 4'b1111 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL scan_capture: digits=%h valid=%b fd=%b, required FA01/1111/1",
                     digits, digit_valid, frame_done);
        end
        step(1);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL scan_fd_width: frame_done=%b, required 0", frame_done);
        end
        step(3);
        checks++;
        if (fd_cnt - fd0 !== 1) begin
            errors++;
            $display("FAIL scan_frames: frames=%0d, required 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_stability();
        do_reset();
        drive(4'b1110, G0, 3);
        drive(4'b1111, BLANK, 1);
        drive(4'b1110, G0, LAT - 1);
        checks++;
        if (digit_valid !== 4'b0000) begin
            errors++;
            $display("FAIL stab_early: valid=%b, required 0000", digit_valid);
        end
        step(1);
        checks++;
        if (digit_valid !== 4'b0001 || digits[3:0] !== 4'h0) begin
            errors++;
            $display("FAIL stab_capture: valid=%b digit0=%h, required 0001/0",
                     digit_valid, digits[3:0]);
        end
    endtask

    task automatic test_seg_err();
        int se0;
        do_reset();
        drive(4'b1110, G5, 8);
        se0 = se_cnt;
        drive(4'b1110, BAD, 6);
        step(2);
        checks++;
        if (se_cnt - se0 !== 1) begin
            errors++;
            $display("FAIL seg_err_count: pulses=%0d, required 1", se_cnt - se0);
        end
        checks++;
        if (digit_valid !== 4'b0001 || digits[3:0] !== 4'h5) begin
            errors++;
            $display("FAIL seg_err_keep: valid=%b digit0=%h, required 0001/5",
                     digit_valid, digits[3:0]);
        end
    endtask

    task automatic test_anode_err();
        int ae0, se0;
        do_reset();
        ae0 = ae_cnt;
        se0 = se_cnt;
        drive(4'b1100, G0, 6);
        step(2);
        checks++;
        if (ae_cnt - ae0 !== 1 || digit_valid !== 4'b0000) begin
            errors++;
            $display("FAIL anode_err_many: pulses=%0d valid=%b, required 1/0000",
                     ae_cnt - ae0, digit_valid);
        end
        drive(4'b1111, G0, 8);
        checks++;
        if (ae_cnt - ae0 !== 1 || se_cnt - se0 !== 0 || digit_valid !== 4'b0000) begin
            errors++;
            $display("FAIL anode_blank: ae=%0d se=%0d valid=%b, required 1/0/0000",
                     ae_cnt - ae0, se_cnt - se0, digit_valid);
        end
    endtask

    task automatic test_recapture();
        int fd0;
        do_reset();
        fd0 = fd_cnt;
        drive(4'b1110, G8, 8);
        checks++;
        if (digits[3:0] !== 4'h8) begin
            errors++;
            $display("FAIL recap_first: digit0=%h, required 8", digits[3:0]);
        end
        drive(4'b1110, G1, 8);
        drive(4'b1101, G0, 8);
        drive(4'b1011, GA, 8);
        checks++;
        if (fd_cnt - fd0 !== 0 || digits[3:0] !== 4'h1) begin
            errors++;
            $display("FAIL recap_noframe: frames=%0d digit0=%h, required 0/1",
                     fd_cnt - fd0, digits[3:0]);
        end
        drive(4'b0111, GF, 8);
        checks++;
        if (fd_cnt - fd0 !== 1 || digits !== 16'hFA01) begin
            errors++;
            $display("FAIL recap_frame: frames=%0d digits=%h, required 1/FA01",
                     fd_cnt - fd0, digits);
        end
    endtask

    task automatic test_reset_mid();
        int fd0;
        do_reset();
        drive(4'b1110, G1, 8);
        drive(4'b1101, G0, 8);
        drive(4'b1011, GA, 2);
        rst_n = 1'b0;
        #1;
        checks++;
        if (digits !== 16'h0 || digit_valid !== 4'b0 ||
            {frame_done, seg_err, anode_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid: digits=%h valid=%b pulses=%b, required 0/0/0",
                     digits, digit_valid, {frame_done, seg_err, anode_err});
        end
        step(2);
        rst_n = 1'b1;
        fd0 = fd_cnt;
        drive(4'b1011, GA, 8);
        drive(4'b0111, GF, 8);
        checks++;
        if (fd_cnt - fd0 !== 0 || digit_valid !== 4'b1100) begin
            errors++;
            $display("FAIL reset_partial: frames=%0d valid=%b, required 0/1100",
                     fd_cnt - fd0, digit_valid);
        end
        drive(4'b1110, G1, 8);
        drive(4'b1101, G0, 8);
        checks++;
        if (fd_cnt - fd0 !== 1 || digits !== 16'hFA01) begin
            errors++;
            $display("FAIL reset_rescan: frames=%0d digits=%h, required 1/FA01",
                     fd_cnt - fd0, digits);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_stability();
        test_seg_err();
        test_anode_err();
        test_recapture();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
